// File: rtl/tile_n_iter.sv
// Walks a layer's tile dimension in chunks of tile_n and issues (base, len, idx, last) descriptors over valid/ready.
// Optional stall counter port stall_cnt is built when TILE_ITER_STATS_EN is defined.
module tile_n_iter #(
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned IDX_W    = 16,
   parameter int unsigned PW_ALIGN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       layer_type,
   input  logic [CNT_W-1:0] total_n,
   input  logic [CNT_W-1:0] tile_n,
   output logic             tile_valid,
   input  logic             tile_ready,
   output logic [CNT_W-1:0] tile_base,
   output logic [CNT_W-1:0] tile_len,
   output logic [IDX_W-1:0] tile_idx,
   output logic             tile_last,
   output logic             busy,
   output logic             done,
   output logic             err
`ifdef TILE_ITER_STATS_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);

   localparam logic [1:0]       LT_PW     = 2'd0;
   localparam logic [CNT_W-1:0] ALIGN_MSK = CNT_W'(PW_ALIGN - 1);
   localparam logic [IDX_W-1:0] IDX_MAX   = {IDX_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_ISSUE = 3'd2,
      S_FIN   = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] total_q;
   logic [CNT_W-1:0] tile_n_q;
   logic [1:0]       type_q;
   logic [CNT_W-1:0] rem_q;

   logic             bad_cfg_c;
   logic [CNT_W-1:0] first_len_c;
   logic [CNT_W-1:0] next_rem_c;
   logic [CNT_W-1:0] next_len_c;

   // Look-ahead for the next descriptor so len/last can be registered with valid
   always_comb begin
      bad_cfg_c   = (tile_n_q == '0) ||
                    ((type_q == LT_PW) && ((tile_n_q & ALIGN_MSK) != '0));
      first_len_c = (total_q < tile_n_q) ? total_q : tile_n_q;
      next_rem_c  = rem_q - tile_len;
      next_len_c  = (next_rem_c < tile_n_q) ? next_rem_c : tile_n_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         total_q    <= '0;
         tile_n_q   <= '0;
         type_q     <= '0;
         rem_q      <= '0;
         tile_valid <= 1'b0;
         tile_base  <= '0;
         tile_len   <= '0;
         tile_idx   <= '0;
         tile_last  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  total_q  <= total_n;
                  tile_n_q <= tile_n;
                  type_q   <= layer_type;
                  busy     <= 1'b1;
                  state    <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (bad_cfg_c) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_ERR;
               end else if (total_q == '0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_FIN;
               end else begin
                  rem_q      <= total_q;
                  tile_valid <= 1'b1;
                  tile_base  <= '0;
                  tile_idx   <= '0;
                  tile_len   <= first_len_c;
                  tile_last  <= (total_q <= tile_n_q);
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (tile_ready) begin
                  if (tile_last) begin
                     tile_valid <= 1'b0;
                     tile_last  <= 1'b0;
                     done       <= 1'b1;
                     busy       <= 1'b0;
                     state      <= S_FIN;
                  end else if (tile_idx == IDX_MAX) begin
                     // Sequence number would wrap: abort the layer
                     tile_valid <= 1'b0;
                     tile_last  <= 1'b0;
                     err        <= 1'b1;
                     busy       <= 1'b0;
                     state      <= S_ERR;
                  end else begin
                     rem_q     <= next_rem_c;
                     tile_base <= tile_base + tile_len;
                     tile_idx  <= tile_idx + IDX_W'(1);
                     tile_len  <= next_len_c;
                     tile_last <= (next_rem_c <= tile_n_q);
                  end
               end
            end
            S_FIN:   state <= S_IDLE;
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef TILE_ITER_STATS_EN
   // Saturating count of back-pressured descriptor cycles, cleared per accepted layer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if ((state == S_IDLE) && start) begin
         stall_cnt <= '0;
      end else if (tile_valid && !tile_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/tile_n_iter.md
Name: tile_n_iter

Overview:
- Consumer side of the tile-size calculation: takes the per-layer `tile_n` (max tiles resident in GLB) and the layer's total tile-dimension count.
- Walks that dimension in chunks of `tile_n`, issuing one (base, length) descriptor per chunk to the GLB load / PE-array dispatch logic over a valid/ready handshake.
- Sits in the controller between the tile-size calculation and the DMA / dispatch FSMs.

Parameters:
- CNT_W, 32, width of total_n, tile_n, tile_base, tile_len
- IDX_W, 16, width of tile_idx (max descriptors per layer = 2^IDX_W)
- PW_ALIGN, 4, required tile_n granularity for pointwise layers (power of two)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse, begin a layer; honoured only in IDLE
- layer_type  input  2  0=PW,1=DW,2=STD,3=LIN; sampled on start
- total_n  input  CNT_W  total units to cover; sampled on start
- tile_n  input  CNT_W  chunk size from tile-size calc; sampled on start
- tile_valid  output  1  descriptor valid
- tile_ready  input  1  downstream accepts descriptor
- tile_base  output  CNT_W  first unit index of this tile
- tile_len  output  CNT_W  units in this tile
- tile_idx  output  IDX_W  sequence number, 0-based
- tile_last  output  1  this descriptor is the final one
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse, layer complete
- err  output  1  one-cycle pulse, layer aborted on bad config

Behaviour:
- Reset (async, rst_n=0): state=IDLE; tile_valid, tile_last, busy, done, err = 0; tile_base, tile_len, tile_idx = 0. Asserting reset mid-layer discards all progress immediately.
- States and transitions:
  - IDLE -> CHECK on start. Latch total_n, tile_n, layer_type. busy=1 from the next cycle.
  - CHECK (1 cycle):
    - tile_n==0 -> ERR.
    - layer_type==PW and tile_n mod PW_ALIGN != 0 -> ERR.
    - total_n==0 -> FIN; no descriptors issued.
    - Otherwise rem=total_n, base=0, idx=0 -> ISSUE.
  - ISSUE: tile_valid=1, tile_base=base, tile_len=min(tile_n, rem), tile_last=(rem<=tile_n), tile_idx=idx.
    - On tile_valid&&tile_ready: if last -> FIN; else base+=tile_len, rem-=tile_len, idx+=1, and stay in ISSUE. The next descriptor is presented in the following cycle, so back-to-back acceptance gives 1 descriptor/cycle.
    - If idx==2^IDX_W-1 and not last at handshake -> ERR (index overflow).
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
  - ERR: err=1 for one cycle, busy=0 -> IDLE.
- Latency: start in cycle t -> first tile_valid in cycle t+2.
- Handshake rules:
  - While tile_valid && !tile_ready, all descriptor outputs hold stable.
  - tile_valid never drops without a handshake, except on reset.
  - tile_ready is ignored when tile_valid=0.
- start while busy is ignored; it is not queued.
- Arithmetic is unsigned CNT_W. base+tile_len never exceeds total_n, so there is no wrap.
- tile_last and tile_len are registered together with tile_valid; no combinational path from tile_ready to outputs.
- tile_last and tile_valid are low in every non-ISSUE state.

Optional Feature:
- Macro: TILE_ITER_STATS_EN.
- When defined:
  - Extra output port stall_cnt (32 bits) counts cycles with tile_valid && !tile_ready.
  - Clears on accepted start and on reset; holds after done/err until the next start; saturates at 2^32-1.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- STD, total_n=10, tile_n=4, tile_ready=1 -> descriptors (base,len,idx,last) = (0,4,0,0), (4,4,1,0), (8,2,2,1) on consecutive cycles starting t+2; done pulse the cycle after the last handshake.
- PW, total_n=8, tile_n=6 -> err pulse 2 cycles after start; no tile_valid; busy back to 0.
- DW, total_n=0, tile_n=5 -> done pulse, zero descriptors; then tile_n=0 with total_n=7 -> err pulse.
- STD, total_n=12, tile_n=4, tile_ready held low 3 cycles on the second descriptor -> (4,4,1,0) held stable for 4 cycles; with TILE_ITER_STATS_EN, stall_cnt=3 at done.
- Exact fit: LIN, total_n=8, tile_n=8 -> single descriptor (0,8,0,1); a second start pulsed while busy is ignored.
- Assert rst_n low while in ISSUE at idx=1 -> all outputs 0 asynchronously; new start after release restarts from base=0, idx=0.
